// File: rtl/soc_periph_arbiter_pkg.sv
// SoC address map, target rules and arbiter types shared by the peripheral arbiter,
// its address decoder and its bus interface.
package ariane_soc;

    localparam int unsigned NrSlaves       = 2;
    localparam int unsigned NB_PERIPHERALS = 10;

    typedef enum int unsigned {
        DRAM = 0, GPIO = 1, Ethernet = 2, SPI = 3, Timer = 4,
        UART = 5, PLIC = 6, CLINT = 7, ROM = 8, Debug = 9
    } axi_slaves_t;

    localparam logic [63:0] DebugBase    = 64'h0000_0000;
    localparam logic [63:0] ROMBase      = 64'h0001_0000;
    localparam logic [63:0] CLINTBase    = 64'h0200_0000;
    localparam logic [63:0] PLICBase     = 64'h0C00_0000;
    localparam logic [63:0] UARTBase     = 64'h1000_0000;
    localparam logic [63:0] TimerBase    = 64'h1800_0000;
    localparam logic [63:0] SPIBase      = 64'h2000_0000;
    localparam logic [63:0] EthernetBase = 64'h3000_0000;
    localparam logic [63:0] GPIOBase     = 64'h4000_0000;
    localparam logic [63:0] DRAMBase     = 64'h8000_0000;

    localparam logic [63:0] DebugLength    = 64'h1000;
    localparam logic [63:0] ROMLength      = 64'h1_0000;
    localparam logic [63:0] CLINTLength    = 64'hC_0000;
    localparam logic [63:0] PLICLength     = 64'h3FF_FFFF;
    localparam logic [63:0] UARTLength     = 64'h1000;
    localparam logic [63:0] TimerLength    = 64'h1000;
    localparam logic [63:0] SPILength      = 64'h80_0000;
    localparam logic [63:0] EthernetLength = 64'h1_0000;
    localparam logic [63:0] GPIOLength     = 64'h1000;
    localparam logic [63:0] DRAMLength     = 64'h4000_0000;

    typedef enum logic [1:0] {IDLE, REQ, RSP, DECERR} arb_state_e;

    typedef struct packed {
        logic [63:0] base;
        logic [63:0] length;
    } target_rule_t;

    // Indexed by axi_slaves_t.
    localparam target_rule_t AddrMap [NB_PERIPHERALS] = '{
        '{DRAMBase,     DRAMLength},
        '{GPIOBase,     GPIOLength},
        '{EthernetBase, EthernetLength},
        '{SPIBase,      SPILength},
        '{TimerBase,    TimerLength},
        '{UARTBase,     UARTLength},
        '{PLICBase,     PLICLength},
        '{CLINTBase,    CLINTLength},
        '{ROMBase,      ROMLength},
        '{DebugBase,    DebugLength}
    };

    typedef struct packed {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  be;
    } mst_req_t;

endpackage

// File: rtl/soc_periph_arbiter_if.sv
// Bus bundle between the core-side masters, the peripheral arbiter and the targets.
// Modport slave is the arbiter's view; modport master is the surrounding fabric's view.
interface soc_periph_arbiter_if #(
    parameter int unsigned NrMasters = ariane_soc::NrSlaves,
    parameter int unsigned NrTargets = ariane_soc::NB_PERIPHERALS
);
    logic [NrMasters-1:0]            mst_req_i;
    logic [NrMasters-1:0][63:0]      mst_addr_i;
    logic [NrMasters-1:0]            mst_we_i;
    logic [NrMasters-1:0][63:0]      mst_wdata_i;
    logic [NrMasters-1:0][7:0]       mst_be_i;
    logic [NrMasters-1:0]            mst_gnt_o;
    logic [NrMasters-1:0]            mst_rvalid_o;
    logic [63:0]                     mst_rdata_o;
    logic                            mst_err_o;

    logic [NrTargets-1:0]            slv_sel_o;
    logic [63:0]                     slv_addr_o;
    logic                            slv_we_o;
    logic [63:0]                     slv_wdata_o;
    logic [7:0]                      slv_be_o;
    logic [NrTargets-1:0]            slv_gnt_i;
    logic [NrTargets-1:0]            slv_rvalid_i;
    logic [NrTargets-1:0][63:0]      slv_rdata_i;
    logic [NrTargets-1:0]            slv_err_i;

    modport slave (
        input  mst_req_i, mst_addr_i, mst_we_i, mst_wdata_i, mst_be_i,
        output mst_gnt_o, mst_rvalid_o, mst_rdata_o, mst_err_o,
        output slv_sel_o, slv_addr_o, slv_we_o, slv_wdata_o, slv_be_o,
        input  slv_gnt_i, slv_rvalid_i, slv_rdata_i, slv_err_i
    );

    modport master (
        output mst_req_i, mst_addr_i, mst_we_i, mst_wdata_i, mst_be_i,
        input  mst_gnt_o, mst_rvalid_o, mst_rdata_o, mst_err_o,
        input  slv_sel_o, slv_addr_o, slv_we_o, slv_wdata_o, slv_be_o,
        output slv_gnt_i, slv_rvalid_i, slv_rdata_i, slv_err_i
    );
endinterface

// File: rtl/soc_addr_decode.sv
// Combinational SoC address decoder: address -> one-hot target select plus hit flag.
module soc_addr_decode import ariane_soc::*; #(
    parameter int unsigned NrTargets = NB_PERIPHERALS
) (
    input  logic [63:0]          i_addr,
    output logic [NrTargets-1:0] o_sel,
    output logic                 o_hit
);
    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        o_sel = '0;
        o_hit = 1'b0;
        for (int t = NrTargets - 1; t >= 0; t--) begin
            if (i_addr >= AddrMap[t].base && (i_addr - AddrMap[t].base) < AddrMap[t].length) begin
                o_sel    = '0;
                o_sel[t] = 1'b1;
                o_hit    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/soc_periph_arbiter.sv
// Round-robin arbiter sharing the peripheral port between core-side masters, one transaction
// in flight. Optional SOC_ARB_TIMEOUT_EN adds a watchdog that errors out a stuck target.
module soc_periph_arbiter import ariane_soc::*; #(
    parameter int unsigned NrMasters = NrSlaves,
    parameter int unsigned NrTargets = NB_PERIPHERALS
`ifdef SOC_ARB_TIMEOUT_EN
    , parameter int unsigned TimeoutCycles = 1024
`endif
) (
    input logic                clk_i,
    input logic                rst_ni,
    soc_periph_arbiter_if.slave bus
);
    localparam int unsigned MstW = (NrMasters > 1) ? $clog2(NrMasters) : 1;

    arb_state_e           r_state;
    logic [MstW-1:0]      r_ptr, r_owner;
    logic [NrTargets-1:0] r_sel, r_tgt;
    mst_req_t             r_req;
    logic [NrMasters-1:0] r_rvalid;
    logic [63:0]          r_rdata;
    logic                 r_err;

    logic                 w_any, w_gnt_ok, w_dec_hit;
    logic [MstW-1:0]      w_win;
    logic [NrMasters-1:0] w_gnt;
    logic [NrTargets-1:0] w_dec_sel;
    logic                 w_tgt_gnt, w_tgt_rv, w_tgt_err, w_tmo;
    logic [63:0]          w_tgt_rdata;

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 0; k < NrMasters; k++) begin
            if (!w_any && bus.mst_req_i[(int'(r_ptr) + k) % NrMasters]) begin
                w_any = 1'b1;
                w_win = MstW'((int'(r_ptr) + k) % NrMasters);
            end
        end
    end

    // No grant while a response pulse is out, so grant and response never share a cycle.
    assign w_gnt_ok = rst_ni && (r_state == IDLE) && !(|r_rvalid);

    always_comb begin
        w_gnt = '0;
        if (w_gnt_ok && w_any) w_gnt[w_win] = 1'b1;
    end

    soc_addr_decode #(.NrTargets(NrTargets)) u_dec (
        .i_addr (bus.mst_addr_i[w_win]),
        .o_sel  (w_dec_sel),
        .o_hit  (w_dec_hit)
    );

    assign w_tgt_gnt = |(bus.slv_gnt_i & r_sel);
    assign w_tgt_rv  = |(bus.slv_rvalid_i & r_tgt);

    always_comb begin
        w_tgt_rdata = '0;
        w_tgt_err   = 1'b0;
        for (int t = 0; t < NrTargets; t++) begin
            if (r_tgt[t]) begin
                w_tgt_rdata = w_tgt_rdata | bus.slv_rdata_i[t];
                w_tgt_err   = w_tgt_err | bus.slv_err_i[t];
            end
        end
    end

`ifdef SOC_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    logic [CntW-1:0] r_cnt;
    logic            w_busy, w_done;

    assign w_busy = (r_state == REQ) || (r_state == RSP);
    assign w_tmo  = w_busy && (r_cnt == CntW'(TimeoutCycles - 1));
    assign w_done = ((r_state == REQ) && w_tgt_gnt && w_tgt_rv) ||
                    ((r_state == RSP) && w_tgt_rv) || w_tmo;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                r_cnt <= '0;
        else if (w_busy && !w_done) r_cnt <= r_cnt + 1'b1;
        else                        r_cnt <= '0;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_sel    <= '0;
            r_tgt    <= '0;
            r_req    <= '0;
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            unique case (r_state)
                IDLE: if (w_gnt_ok && w_any) begin
                    r_owner <= w_win;
                    r_ptr   <= MstW'((int'(w_win) + 1) % NrMasters);
                    r_req   <= '{addr: bus.mst_addr_i[w_win], we: bus.mst_we_i[w_win],
                                 wdata: bus.mst_wdata_i[w_win], be: bus.mst_be_i[w_win]};
                    r_sel   <= w_dec_sel;
                    r_tgt   <= w_dec_sel;
                    r_state <= w_dec_hit ? REQ : DECERR;
                end
                REQ: if (w_tgt_gnt) begin
                    r_sel <= '0;
                    if (w_tgt_rv) begin
                        r_rvalid[r_owner] <= 1'b1;
                        r_rdata           <= w_tgt_rdata;
                        r_err             <= w_tgt_err;
                        r_state           <= IDLE;
                    end else begin
                        r_state <= RSP;
                    end
                end else if (w_tmo) begin
                    r_sel             <= '0;
                    r_rvalid[r_owner] <= 1'b1;
                    r_err             <= 1'b1;
                    r_state           <= IDLE;
                end
                RSP: if (w_tgt_rv) begin
                    r_rvalid[r_owner] <= 1'b1;
                    r_rdata           <= w_tgt_rdata;
                    r_err             <= w_tgt_err;
                    r_state           <= IDLE;
                end else if (w_tmo) begin
                    r_rvalid[r_owner] <= 1'b1;
                    r_err             <= 1'b1;
                    r_state           <= IDLE;
                end
                DECERR: begin
                    r_rvalid[r_owner] <= 1'b1;
                    r_err             <= 1'b1;
                    r_state           <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mst_gnt_o    = w_gnt;
    assign bus.mst_rvalid_o = r_rvalid;
    assign bus.mst_rdata_o  = r_rdata;
    assign bus.mst_err_o    = r_err;
    assign bus.slv_sel_o    = r_sel;
    assign bus.slv_addr_o   = r_req.addr;
    assign bus.slv_we_o     = r_req.we;
    assign bus.slv_wdata_o  = r_req.wdata;
    assign bus.slv_be_o     = r_req.be;
endmodule

// File: tb/tb_soc_periph_arbiter.sv
// Directed self-checking bench for soc_periph_arbiter; inputs driven between edges,
// outputs sampled on the falling edge.
module tb_soc_periph_arbiter;
    import ariane_soc::*;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   n_chk  = 0;
    int   n_fail = 0;

    soc_periph_arbiter_if #(.NrMasters(NrSlaves), .NrTargets(NB_PERIPHERALS)) bus ();

`ifdef SOC_ARB_TIMEOUT_EN
    soc_periph_arbiter #(.TimeoutCycles(16)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
`else
    soc_periph_arbiter dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
`endif

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] onehot(input int unsigned t);
        return 64'd1 << t;
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        bus.mst_req_i    = '0;
        bus.mst_addr_i   = '0;
        bus.mst_we_i     = '0;
        bus.mst_wdata_i  = '0;
        bus.mst_be_i     = '0;
        bus.slv_gnt_i    = '0;
        bus.slv_rvalid_i = '0;
        bus.slv_rdata_i  = '0;
        bus.slv_err_i    = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        rst_ni = 1'b1;
    endtask

    task automatic outs_zero(input string tag);
        check({tag, ".gnt"},    64'(bus.mst_gnt_o), 64'd0);
        check({tag, ".rvalid"}, 64'(bus.mst_rvalid_o), 64'd0);
        check({tag, ".rdata"},  bus.mst_rdata_o, 64'd0);
        check({tag, ".err"},    64'(bus.mst_err_o), 64'd0);
        check({tag, ".sel"},    64'(bus.slv_sel_o), 64'd0);
        check({tag, ".addr"},   bus.slv_addr_o, 64'd0);
        check({tag, ".we"},     64'(bus.slv_we_o), 64'd0);
        check({tag, ".wdata"},  bus.slv_wdata_o, 64'd0);
        check({tag, ".be"},     64'(bus.slv_be_o), 64'd0);
    endtask

    // Single m0 read; a hit is granted and answered in the cycle after selection.
    task automatic probe(input string tag, input logic [63:0] addr, input logic [63:0] exp_sel);
        bus.mst_req_i[0]  = 1'b1;
        bus.mst_addr_i[0] = addr;
        bus.mst_we_i[0]   = 1'b0;
        mid();
        check({tag, ".gnt"}, 64'(bus.mst_gnt_o), 64'd1);
        cyc();
        bus.mst_req_i[0] = 1'b0;
        mid();
        check({tag, ".sel"}, 64'(bus.slv_sel_o), exp_sel);
        for (int t = 0; t < NB_PERIPHERALS; t++) bus.slv_rdata_i[t] = ~addr;
        bus.slv_gnt_i    = exp_sel[NB_PERIPHERALS-1:0];
        bus.slv_rvalid_i = exp_sel[NB_PERIPHERALS-1:0];
        cyc();
        bus.slv_gnt_i    = '0;
        bus.slv_rvalid_i = '0;
        mid();
        check({tag, ".rv"},    64'(bus.mst_rvalid_o), 64'd1);
        check({tag, ".err"},   64'(bus.mst_err_o), (exp_sel == 64'd0) ? 64'd1 : 64'd0);
        check({tag, ".rdata"}, bus.mst_rdata_o, (exp_sel == 64'd0) ? 64'd0 : ~addr);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          m, t, got0, got1;
        logic [63:0] d;

        // Reset: outputs quiet even with requests pending.
        rst_ni = 1'b0;
        idle_inputs();
        bus.mst_req_i     = '1;
        bus.mst_addr_i[0] = 64'h1000_0000;
        mid();
        outs_zero("reset");
        cyc();
        bus.mst_req_i = '0;
        rst_ni        = 1'b1;

        // m0 read of UART; a stray grant from GPIO must be ignored.
        bus.mst_req_i[0]  = 1'b1;
        bus.mst_addr_i[0] = 64'h1000_0010;
        mid();
        check("t1.gnt", 64'(bus.mst_gnt_o), 64'd1);
        cyc();
        bus.mst_req_i[0]    = 1'b0;
        bus.slv_gnt_i[GPIO] = 1'b1;
        mid();
        check("t1.sel1", 64'(bus.slv_sel_o), onehot(UART));
        check("t1.addr", bus.slv_addr_o, 64'h1000_0010);
        cyc();
        bus.slv_gnt_i       = '0;
        bus.slv_gnt_i[UART] = 1'b1;
        mid();
        check("t1.sel2", 64'(bus.slv_sel_o), onehot(UART));
        cyc();
        bus.slv_gnt_i = '0;
        mid();
        check("t1.sel3", 64'(bus.slv_sel_o), 64'd0);
        cyc();
        bus.slv_rvalid_i[UART] = 1'b1;
        bus.slv_rdata_i[UART]  = 64'hAB;
        mid();
        check("t1.rv4", 64'(bus.mst_rvalid_o), 64'd0);
        cyc();
        bus.slv_rvalid_i = '0;
        mid();
        check("t1.rv5", 64'(bus.mst_rvalid_o), 64'd1);
        check("t1.rdata", bus.mst_rdata_o, 64'hAB);
        check("t1.err", 64'(bus.mst_err_o), 64'd0);
        cyc();
        mid();
        check("t1.rv6", 64'(bus.mst_rvalid_o), 64'd0);

        // Both masters requesting continuously: grants alternate from reset.
        do_reset();
        bus.mst_req_i     = '1;
        bus.mst_addr_i[0] = 64'h1000_0000;
        bus.mst_addr_i[1] = 64'h1800_0008;
        got0 = 0;
        got1 = 0;
        for (int n = 0; n < 4; n++) begin
            m = n % 2;
            t = (m == 0) ? int'(UART) : int'(Timer);
            d = 64'h100 + 64'(n);
            mid();
            check("t2.gnt", 64'(bus.mst_gnt_o), onehot(m));
            cyc();
            mid();
            check("t2.sel", 64'(bus.slv_sel_o), onehot(t));
            check("t2.addr", bus.slv_addr_o, (m == 0) ? 64'h1000_0000 : 64'h1800_0008);
            bus.slv_gnt_i[t]   = 1'b1;
            bus.slv_rdata_i[t] = d;
            if (m == 1) bus.slv_rvalid_i[t] = 1'b1;
            cyc();
            bus.slv_gnt_i    = '0;
            bus.slv_rvalid_i = '0;
            if (m == 0) begin
                mid();
                check("t2.rsp_sel", 64'(bus.slv_sel_o), 64'd0);
                bus.slv_rvalid_i[t] = 1'b1;
                cyc();
                bus.slv_rvalid_i = '0;
            end
            mid();
            check("t2.rv", 64'(bus.mst_rvalid_o), onehot(m));
            check("t2.rdata", bus.mst_rdata_o, d);
            check("t2.gnt_blocked", 64'(bus.mst_gnt_o), 64'd0);
            if (bus.mst_rvalid_o[0]) got0++;
            if (bus.mst_rvalid_o[1]) got1++;
            cyc();
        end
        bus.mst_req_i = '0;
        check("t2.count_m0", 64'(got0), 64'd2);
        check("t2.count_m1", 64'(got1), 64'd2);

        // m1 write to an unmapped hole.
        bus.mst_req_i[1]   = 1'b1;
        bus.mst_addr_i[1]  = 64'h5000_0000;
        bus.mst_we_i[1]    = 1'b1;
        bus.mst_wdata_i[1] = 64'hDEAD_BEEF;
        bus.mst_be_i[1]    = 8'hF0;
        mid();
        check("t3.gnt", 64'(bus.mst_gnt_o), 64'd2);
        cyc();
        bus.mst_req_i = '0;
        mid();
        check("t3.sel", 64'(bus.slv_sel_o), 64'd0);
        check("t3.rv1", 64'(bus.mst_rvalid_o), 64'd0);
        check("t3.we", 64'(bus.slv_we_o), 64'd1);
        check("t3.wdata", bus.slv_wdata_o, 64'hDEAD_BEEF);
        check("t3.be", 64'(bus.slv_be_o), 64'hF0);
        cyc();
        mid();
        check("t3.rv2", 64'(bus.mst_rvalid_o), 64'd2);
        check("t3.err", 64'(bus.mst_err_o), 64'd1);
        check("t3.rdata", bus.mst_rdata_o, 64'd0);
        cyc();
        bus.mst_we_i = '0;

        // Decode boundaries.
        probe("dram_last",  64'hBFFF_FFFF, onehot(DRAM));
        probe("dram_end",   64'hC000_0000, 64'd0);
        probe("debug_last", 64'h0000_0FFF, onehot(Debug));
        probe("rom_gap",    64'h0000_1000, 64'd0);
        probe("clint_base", 64'h0200_0000, onehot(CLINT));
        probe("plic_last",  64'h0FFF_FFFE, onehot(PLIC));
        probe("high_miss",  64'hFFFF_FFFF_0000_0000, 64'd0);

        // Reset while waiting on CLINT; the late response must vanish.
        bus.mst_req_i[0]  = 1'b1;
        bus.mst_addr_i[0] = 64'h0200_0008;
        mid();
        check("t5.gnt", 64'(bus.mst_gnt_o), 64'd1);
        cyc();
        bus.mst_req_i = '0;
        mid();
        check("t5.sel", 64'(bus.slv_sel_o), onehot(CLINT));
        bus.slv_gnt_i[CLINT] = 1'b1;
        cyc();
        bus.slv_gnt_i = '0;
        mid();
        check("t5.addr_rsp", bus.slv_addr_o, 64'h0200_0008);
        rst_ni = 1'b0;
        #1;
        outs_zero("t5.rst");
        cyc();
        rst_ni = 1'b1;
        bus.slv_rvalid_i[CLINT] = 1'b1;
        bus.slv_rdata_i[CLINT]  = 64'h55;
        cyc();
        bus.slv_rvalid_i = '0;
        mid();
        check("t5.stale_rv1", 64'(bus.mst_rvalid_o), 64'd0);
        cyc();
        mid();
        check("t5.stale_rv2", 64'(bus.mst_rvalid_o), 64'd0);

`ifdef SOC_ARB_TIMEOUT_EN
        // Target never grants: forced error after 16 busy cycles.
        do_reset();
        bus.mst_req_i[0]  = 1'b1;
        bus.mst_addr_i[0] = 64'h1000_0000;
        mid();
        check("t6.gnt", 64'(bus.mst_gnt_o), 64'd1);
        cyc();
        bus.mst_req_i = '0;
        for (int c = 1; c <= 16; c++) begin
            mid();
            check("t6.wait_rv", 64'(bus.mst_rvalid_o), 64'd0);
            if (c == 16) check("t6.sel16", 64'(bus.slv_sel_o), onehot(UART));
            cyc();
        end
        bus.mst_req_i[0] = 1'b1;
        mid();
        check("t6.tmo_rv", 64'(bus.mst_rvalid_o), 64'd1);
        check("t6.tmo_err", 64'(bus.mst_err_o), 64'd1);
        check("t6.tmo_sel", 64'(bus.slv_sel_o), 64'd0);
        check("t6.tmo_gnt", 64'(bus.mst_gnt_o), 64'd0);
        cyc();
        mid();
        check("t6.regnt", 64'(bus.mst_gnt_o), 64'd1);
        cyc();
        bus.mst_req_i          = '0;
        bus.slv_gnt_i[UART]    = 1'b1;
        bus.slv_rvalid_i[UART] = 1'b1;
        bus.slv_rdata_i[UART]  = 64'h77;
        cyc();
        bus.slv_gnt_i    = '0;
        bus.slv_rvalid_i = '0;
        mid();
        check("t6.rv_ok", 64'(bus.mst_rvalid_o), 64'd1);
        check("t6.err_ok", 64'(bus.mst_err_o), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
